// File: rtl/csa_pkg.sv
// Shared constants, pipeline-geometry helpers and stage control fields for csa_pipe_adder.
package csa_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Bits resolved per pipeline stage.
    function automatic int csa_slice(input int blk, input int pipe_blks);
        return blk * pipe_blks;
    endfunction

    // Number of compute stages after the operand register.
    function automatic int csa_nstage(input int width, input int blk, input int pipe_blks);
        return width / (blk * pipe_blks);
    endfunction

    typedef struct packed {
        logic valid;
        logic sub;
        logic carry;
    } stage_ctrl_t;

endpackage

// File: rtl/csa_block.sv
// One BLK-bit adder block: plain ripple, or dual ripple (cin=0/1) with the result picked by cin.
module csa_block #(
    parameter int BLK          = 4,
    parameter bit CARRY_SELECT = 1'b1
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           cin,
    output logic [BLK-1:0] sum,
    output logic           cout
);

    logic [BLK:0]   c_lo;
    logic [BLK-1:0] s_lo;

    for (genvar gi = 0; gi < BLK; gi++) begin : g_lo
        assign s_lo[gi]   = a[gi] ^ b[gi] ^ c_lo[gi];
        assign c_lo[gi+1] = (a[gi] & b[gi]) | (c_lo[gi] & (a[gi] ^ b[gi]));
    end

    if (CARRY_SELECT) begin : g_select
        logic [BLK:0]   c_hi;
        logic [BLK-1:0] s_hi;

        assign c_lo[0] = 1'b0;
        assign c_hi[0] = 1'b1;

        for (genvar gi = 0; gi < BLK; gi++) begin : g_hi
            assign s_hi[gi]   = a[gi] ^ b[gi] ^ c_hi[gi];
            assign c_hi[gi+1] = (a[gi] & b[gi]) | (c_hi[gi] & (a[gi] ^ b[gi]));
        end

        // Both speculative sums are ready before cin arrives; cin only drives the mux.
        assign sum  = cin ? s_hi : s_lo;
        assign cout = cin ? c_hi[BLK] : c_lo[BLK];
    end else begin : g_ripple
        assign c_lo[0] = cin;
        assign sum     = s_lo;
        assign cout    = c_lo[BLK];
    end

endmodule

// File: rtl/csa_pipe_adder.sv
// Skewed pipelined carry-select adder/subtractor with valid/ready on both sides.
// Optional status flags (out_ovf/out_zero/out_neg) are built when CSA_FLAGS_EN is defined.
module csa_pipe_adder
    import csa_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int BLK       = 4,
    parameter int PIPE_BLKS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
`ifdef CSA_FLAGS_EN
    ,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg
`endif
);

    localparam int S      = csa_slice(BLK, PIPE_BLKS);
    localparam int NSTAGE = csa_nstage(WIDTH, BLK, PIPE_BLKS);

    typedef struct packed {
        stage_ctrl_t      ctrl;
        logic [WIDTH-1:0] a_rem;
        logic [WIDTH-1:0] b_rem;
        logic [WIDTH-1:0] sum_done;
    } stage_t;

    logic   advance;
    stage_t in_reg;

    // Whole pipeline moves as one; a stalled output freezes every rank including bubbles.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Operand register: B is inverted here for subtract so stages only ever add.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_reg <= '0;
        end else if (advance) begin
            in_reg.ctrl.valid <= in_valid;
            in_reg.ctrl.sub   <= in_sub;
            in_reg.ctrl.carry <= (in_sub == OP_SUB) ? 1'b1 : in_cin;
            in_reg.a_rem      <= in_a;
            in_reg.b_rem      <= (in_sub == OP_SUB) ? ~in_b : in_b;
            in_reg.sum_done   <= '0;
        end
    end

    for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_stage
        stage_t               prev;
        stage_t               st_next;
        stage_t               st_reg;
        logic [PIPE_BLKS:0]   blk_c;
        logic [S-1:0]         slice_sum;

        if (gi == 0) begin : g_first
            assign prev = in_reg;
        end else begin : g_chain
            assign prev = g_stage[gi-1].st_reg;
        end

        assign blk_c[0] = prev.ctrl.carry;

        for (genvar gj = 0; gj < PIPE_BLKS; gj++) begin : g_blk
            // The very first block sees a known carry-in at once, so it needs no select pair.
            csa_block #(
                .BLK          (BLK),
                .CARRY_SELECT ((gi == 0 && gj == 0) ? 1'b0 : 1'b1)
            ) u_blk (
                .a    (prev.a_rem[gi*S + gj*BLK +: BLK]),
                .b    (prev.b_rem[gi*S + gj*BLK +: BLK]),
                .cin  (blk_c[gj]),
                .sum  (slice_sum[gj*BLK +: BLK]),
                .cout (blk_c[gj+1])
            );
        end

        always_comb begin
            st_next                  = prev;
            st_next.a_rem[gi*S +: S] = '0;
            st_next.b_rem[gi*S +: S] = '0;
            st_next.sum_done[gi*S +: S] = slice_sum;
            st_next.ctrl.carry       = blk_c[PIPE_BLKS];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                st_reg <= '0;
            end else if (advance) begin
                st_reg <= st_next;
            end
        end
    end

    assign out_valid = g_stage[NSTAGE-1].st_reg.ctrl.valid;
    assign out_sum   = g_stage[NSTAGE-1].st_reg.sum_done;
    assign out_cout  = g_stage[NSTAGE-1].st_reg.ctrl.carry;

    // Fully consumed operand fields and the op bit have no reader past the last stage.
    logic unused_tail;
    assign unused_tail = ^{g_stage[NSTAGE-1].st_reg.ctrl.sub,
                           g_stage[NSTAGE-1].st_reg.a_rem,
                           g_stage[NSTAGE-1].st_reg.b_rem};

`ifdef CSA_FLAGS_EN
    logic flag_a_msb;
    logic flag_b_msb;
    logic flag_s_msb;
    logic flag_cout;
    logic flag_ovf;

    assign flag_a_msb = g_stage[NSTAGE-1].prev.a_rem[WIDTH-1];
    assign flag_b_msb = g_stage[NSTAGE-1].prev.b_rem[WIDTH-1];
    assign flag_s_msb = g_stage[NSTAGE-1].st_next.sum_done[WIDTH-1];
    assign flag_cout  = g_stage[NSTAGE-1].st_next.ctrl.carry;
    // a^b^sum at the MSB recovers the carry into the MSB.
    assign flag_ovf   = (flag_a_msb ^ flag_b_msb ^ flag_s_msb) ^ flag_cout;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_ovf  <= 1'b0;
            out_zero <= 1'b0;
            out_neg  <= 1'b0;
        end else if (advance) begin
            out_ovf  <= flag_ovf;
            out_zero <= (g_stage[NSTAGE-1].st_next.sum_done == '0);
            out_neg  <= flag_s_msb;
        end
    end
`endif

endmodule
